iq_stream_packer: RTL and testbench

- Sits directly upstream of the stream-to-AXI bridge, in the Sclk domain.
- Takes raw receive I/Q samples from the RF front-end interface and optionally decimates them.
- Packs them into 32-bit words and drives the bridge's Sin/Ien/sync inputs.
- Provides a start/stop control path and a word counter for software.

---
 rtl/iq_stream_packer.sv | 166 ++++++++++++++++
 tb/tb_iq_stream_packer.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iq_stream_packer.sv
// Purpose : decimates receive I/Q samples and packs them into 32-bit words for the stream-to-AXI bridge.
// Latency : one Sclk cycle from an accepted sample (or the FLUSH cycle) to the Ien pulse.
// Backpressure: none; the bridge must take every Ien pulse, and rx samples are never stalled.
//
// Ports:
//   Sclk, rst            stream clock, asynchronous active-low reset
//   arm, stop            level-sampled capture start / stop requests
//   mode, dec            packing mode and decimation ratio minus one, latched on arm
//   rx_valid, rx_i, rx_q signed I/Q sample stream from the RF front-end
//   Sin, Ien             packed word and its one-cycle valid strobe
//   sync                 one-cycle pulse while a new capture is being set up
//   busy                 high while a capture is in SYNC, RUN or FLUSH
//   wcnt                 words emitted since the last sync
module iq_stream_packer #(
    parameter int IQW = 12
) (
    input  logic           Sclk,
    input  logic           rst,
    input  logic           arm,
    input  logic           stop,
    input  logic           mode,
    input  logic [7:0]     dec,
    input  logic           rx_valid,
    input  logic [IQW-1:0] rx_i,
    input  logic [IQW-1:0] rx_q,
    output logic [31:0]    Sin,
    output logic           Ien,
    output logic           sync,
    output logic           busy,
    output logic [31:0]    wcnt
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SYNC  = 2'd1;
    localparam logic [1:0] S_RUN   = 2'd2;
    localparam logic [1:0] S_FLUSH = 2'd3;

    logic [1:0]  state_q, state_d;
    logic        mode_q,  mode_d;
    logic [7:0]  dec_q,   dec_d;
    logic [7:0]  cnt_q,   cnt_d;
    logic        half_q,  half_d;
    logic [15:0] hold_q,  hold_d;
    logic [31:0] sin_q,   sin_d;
    logic        ien_q,   ien_d;
    logic [31:0] wcnt_q,  wcnt_d;

    logic [15:0] i_ext;
    logic [15:0] q_ext;
    logic [15:0] b_cur;
    logic        accept;

    // Full-precision samples are sign-extended to 16 bits; the truncated form keeps the top byte of each.
    assign i_ext  = 16'($signed(rx_i));
    assign q_ext  = 16'($signed(rx_q));
    assign b_cur  = {rx_q[IQW-1 -: 8], rx_i[IQW-1 -: 8]};
    assign accept = (state_q == S_RUN) && rx_valid && (cnt_q == 8'd0);

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        dec_d   = dec_q;
        cnt_d   = cnt_q;
        half_d  = half_q;
        hold_d  = hold_q;
        sin_d   = sin_q;
        ien_d   = 1'b0;
        wcnt_d  = wcnt_q;

        case (state_q)
            S_IDLE: begin
                // stop has priority over arm
                if (arm && !stop) begin
                    state_d = S_SYNC;
                    mode_d  = mode;
                    dec_d   = dec;
                end
            end

            S_SYNC: begin
                cnt_d   = 8'd0;
                half_d  = 1'b0;
                wcnt_d  = 32'd0;
                state_d = stop ? S_IDLE : S_RUN;
            end

            S_RUN: begin
                // Counter only moves on valid samples; zero means "take this one".
                if (rx_valid) begin
                    if (cnt_q == 8'd0) begin
                        cnt_d = dec_q;
                    end else begin
                        cnt_d = cnt_q - 8'd1;
                    end
                end

                if (accept) begin
                    if (!mode_q) begin
                        sin_d = {q_ext, i_ext};
                        ien_d = 1'b1;
                    end else if (!half_q) begin
                        hold_d = b_cur;
                        half_d = 1'b1;
                    end else begin
                        sin_d  = {b_cur, hold_q};
                        ien_d  = 1'b1;
                        half_d = 1'b0;
                    end
                end

                // Decide on the half flag as updated by this cycle's sample, so a
                // sample that completes a word alongside stop skips the flush.
                if (stop) begin
                    state_d = (mode_q && half_d) ? S_FLUSH : S_IDLE;
                end
            end

            S_FLUSH: begin
                sin_d   = {16'h0000, hold_q};
                ien_d   = 1'b1;
                half_d  = 1'b0;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Count the word in the same edge that raises Ien so wcnt tracks the pulses seen.
        if (ien_d) begin
            wcnt_d = wcnt_q + 32'd1;
        end
    end

    always_ff @(posedge Sclk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            mode_q  <= 1'b0;
            dec_q   <= 8'd0;
            cnt_q   <= 8'd0;
            half_q  <= 1'b0;
            hold_q  <= 16'd0;
            sin_q   <= 32'd0;
            ien_q   <= 1'b0;
            wcnt_q  <= 32'd0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            dec_q   <= dec_d;
            cnt_q   <= cnt_d;
            half_q  <= half_d;
            hold_q  <= hold_d;
            sin_q   <= sin_d;
            ien_q   <= ien_d;
            wcnt_q  <= wcnt_d;
        end
    end

    assign Sin  = sin_q;
    assign Ien  = ien_q;
    assign wcnt = wcnt_q;
    assign sync = (state_q == S_SYNC);
    assign busy = (state_q != S_IDLE);

endmodule

// File: tb/tb_iq_stream_packer.sv
module tb_iq_stream_packer;

    logic        Sclk;
    logic        rst;
    logic        arm;
    logic        stop;
    logic        mode;
    logic [7:0]  dec;
    logic        rx_valid;
    logic [11:0] rx_i;
    logic [11:0] rx_q;
    logic [31:0] Sin;
    logic        Ien;
    logic        sync;
    logic        busy;
    logic [31:0] wcnt;

    int n_cmp = 0;
    int n_err = 0;

    // Sample stimulus for the next capture, and words observed on the Ien strobe.
    logic [11:0] si[$];
    logic [11:0] sq[$];
    bit          sv[$];
    logic [31:0] got[$];

    iq_stream_packer #(.IQW(12)) dut (
        .Sclk     (Sclk),
        .rst      (rst),
        .arm      (arm),
        .stop     (stop),
        .mode     (mode),
        .dec      (dec),
        .rx_valid (rx_valid),
        .rx_i     (rx_i),
        .rx_q     (rx_q),
        .Sin      (Sin),
        .Ien      (Ien),
        .sync     (sync),
        .busy     (busy),
        .wcnt     (wcnt)
    );

    initial Sclk = 1'b0;
    always #5 Sclk = ~Sclk;

    // Word monitor, sampling well after the rising edge.
    always begin
        @(posedge Sclk);
        #2;
        if (Ien === 1'b1) got.push_back(Sin);
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(posedge Sclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clear_samples();
        si.delete();
        sq.delete();
        sv.delete();
    endtask

    task automatic add_sample(input bit v, input logic [11:0] i, input logic [11:0] q);
        sv.push_back(v);
        si.push_back(i);
        sq.push_back(q);
    endtask

    task automatic fill_random();
        int n;
        clear_samples();
        n = $urandom_range(10, 30);
        for (int j = 0; j < n; j++) begin
            add_sample($urandom_range(0, 9) < 7, 12'($urandom), 12'($urandom));
        end
    endtask

    // IDLE -> SYNC -> RUN, with junk rx_valid and changing mode/dec during SYNC.
    task automatic do_arm(input bit m, input logic [7:0] d);
        arm  = 1'b1;
        stop = 1'b0;
        mode = m;
        dec  = d;
        cyc();
        chk("sync_pulse", {31'd0, sync}, 32'd1);
        chk("busy_sync", {31'd0, busy}, 32'd1);
        arm      = 1'b0;
        mode     = ~m;
        dec      = ~d;
        rx_valid = 1'b1;
        rx_i     = 12'($urandom);
        rx_q     = 12'($urandom);
        cyc();
        chk("sync_end", {31'd0, sync}, 32'd0);
        chk("busy_run", {31'd0, busy}, 32'd1);
        chk("wcnt_cleared", wcnt, 32'd0);
        chk("ien_after_sync", {31'd0, Ien}, 32'd0);
    endtask

    // One full capture over the queued samples, checked against a plain model:
    // every (d+1)-th valid sample is kept, then packed one or two per word.
    task automatic run_capture(input bit m, input logic [7:0] d, input bit stop_on_last);
        int          k;
        int          n;
        bit          hv;
        bit          got_w;
        logic [15:0] hb;
        logic [15:0] b;
        logic [31:0] w;
        logic [31:0] exp_q[$];
        k  = 0;
        hv = 1'b0;
        hb = 16'd0;
        w  = 32'd0;
        n  = si.size();
        got.delete();
        do_arm(m, d);
        for (int j = 0; j < n; j++) begin
            rx_valid = sv[j];
            rx_i     = si[j];
            rx_q     = sq[j];
            stop     = stop_on_last && (j == n - 1);
            mode     = 1'($urandom);
            dec      = 8'($urandom);
            got_w    = 1'b0;
            if (sv[j]) begin
                if (k % (d + 1) == 0) begin
                    if (!m) begin
                        w = {{4{sq[j][11]}}, sq[j], {4{si[j][11]}}, si[j]};
                        got_w = 1'b1;
                    end else begin
                        b = {sq[j][11:4], si[j][11:4]};
                        if (!hv) begin
                            hb = b;
                            hv = 1'b1;
                        end else begin
                            w = {b, hb};
                            hv = 1'b0;
                            got_w = 1'b1;
                        end
                    end
                    if (got_w) exp_q.push_back(w);
                end
                k++;
            end
            cyc();
            chk("ien_step", {31'd0, Ien}, {31'd0, got_w});
            if (got_w) chk("sin_step", Sin, w);
        end
        if (!stop_on_last) begin
            rx_valid = 1'b0;
            stop     = 1'b1;
            cyc();
            chk("ien_stop", {31'd0, Ien}, 32'd0);
        end
        rx_valid = 1'b0;
        stop     = 1'b0;
        chk("busy_after_stop", {31'd0, busy}, {31'd0, hv});
        if (hv) begin
            w = {16'h0000, hb};
            exp_q.push_back(w);
            cyc();
            chk("ien_flush", {31'd0, Ien}, 32'd1);
            chk("sin_flush", Sin, w);
            chk("busy_after_flush", {31'd0, busy}, 32'd0);
        end
        repeat (3) cyc();
        chk("ien_idle", {31'd0, Ien}, 32'd0);
        chk("busy_idle", {31'd0, busy}, 32'd0);
        chk("wcnt_final", wcnt, 32'(exp_q.size()));
        chk("word_count", 32'(got.size()), 32'(exp_q.size()));
        for (int j = 0; j < exp_q.size() && j < got.size(); j++) begin
            chk("word", got[j], exp_q[j]);
        end
    endtask

    initial begin
        rst      = 1'b0;
        arm      = 1'b0;
        stop     = 1'b0;
        mode     = 1'b0;
        dec      = 8'd0;
        rx_valid = 1'b0;
        rx_i     = 12'd0;
        rx_q     = 12'd0;
        repeat (3) cyc();
        chk("rst_sin", Sin, 32'd0);
        chk("rst_ien", {31'd0, Ien}, 32'd0);
        chk("rst_sync", {31'd0, sync}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_wcnt", wcnt, 32'd0);
        rst = 1'b1;
        cyc();

        // Full-scale samples, one word each.
        clear_samples();
        for (int j = 0; j < 4; j++) add_sample(1'b1, 12'h7FF, 12'h800);
        run_capture(1'b0, 8'd0, 1'b0);
        chk("t1_word", (got.size() > 0) ? got[0] : 32'hx, 32'hF800_07FF);

        // Decimate by 4 over a ramp.
        clear_samples();
        for (int j = 0; j < 16; j++) add_sample(1'b1, 12'(j), 12'($urandom));
        run_capture(1'b0, 8'd3, 1'b0);
        chk("t2_low3", (got.size() > 3) ? {16'd0, got[3][15:0]} : 32'hx, 32'h0000_000C);

        // Two truncated pairs into one word.
        clear_samples();
        add_sample(1'b1, 12'h120, 12'h340);
        add_sample(1'b1, 12'h560, 12'h780);
        run_capture(1'b1, 8'd0, 1'b0);
        chk("t3_word", (got.size() > 0) ? got[0] : 32'hx, 32'h7856_3412);

        // Odd sample count with stop on the last sample: flush word.
        clear_samples();
        for (int j = 0; j < 3; j++) add_sample(1'b1, 12'($urandom), 12'($urandom));
        run_capture(1'b1, 8'd0, 1'b1);

        // Stop on a sample that completes a word: no flush.
        clear_samples();
        for (int j = 0; j < 2; j++) add_sample(1'b1, 12'($urandom), 12'($urandom));
        run_capture(1'b1, 8'd0, 1'b1);

        // arm and stop together: stop wins.
        arm  = 1'b1;
        stop = 1'b1;
        cyc();
        chk("armstop_sync", {31'd0, sync}, 32'd0);
        chk("armstop_busy", {31'd0, busy}, 32'd0);
        cyc();
        chk("armstop_busy2", {31'd0, busy}, 32'd0);

        // stop during SYNC: pulse still issued, then back to IDLE.
        stop = 1'b0;
        cyc();
        chk("sync_with_stop", {31'd0, sync}, 32'd1);
        arm  = 1'b0;
        stop = 1'b1;
        cyc();
        chk("sync_stop_busy", {31'd0, busy}, 32'd0);
        chk("sync_stop_wcnt", wcnt, 32'd0);
        stop = 1'b0;
        cyc();

        // Reset mid-RUN with a half word held.
        got.delete();
        do_arm(1'b1, 8'd0);
        for (int j = 0; j < 3; j++) begin
            rx_valid = 1'b1;
            rx_i     = 12'($urandom);
            rx_q     = 12'($urandom);
            cyc();
        end
        rx_valid = 1'b0;
        cyc();
        rst = 1'b0;
        #1;
        chk("arst_sin", Sin, 32'd0);
        chk("arst_ien", {31'd0, Ien}, 32'd0);
        chk("arst_sync", {31'd0, sync}, 32'd0);
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_wcnt", wcnt, 32'd0);
        cyc();
        rst = 1'b1;
        repeat (3) cyc();
        chk("arst_no_flush", 32'(got.size()), 32'd1);
        chk("arst_idle_busy", {31'd0, busy}, 32'd0);

        // Randomised captures (mode/dec inputs wiggle throughout RUN).
        for (int r = 0; r < 8; r++) begin
            fill_random();
            run_capture(1'($urandom), 8'($urandom_range(0, 4)), 1'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
